// File: rtl/edge_evt_arb.sv
// Multi-channel edge-event controller: per-channel edge detect, one-deep pending slot, round-robin event port.
// Optional event timestamps are enabled by defining EDGE_EVT_TS_EN.
module edge_evt_arb #(
    parameter int unsigned NCH = 4,
    parameter int unsigned IDW = 2,
    parameter int unsigned TSW = 16
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [NCH-1:0] s,
    input  logic [NCH-1:0] cfg_pos,
    input  logic [NCH-1:0] cfg_neg,
    input  logic           en,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [IDW-1:0] evt_id,
    output logic           evt_rise,
    output logic [NCH-1:0] ovf,
    input  logic [NCH-1:0] ovf_clr
`ifdef EDGE_EVT_TS_EN
    ,
    output logic [TSW-1:0] evt_ts
`endif
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [NCH-1:0] s_r_q;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] pend_rise_q, pend_rise_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [NCH-1:0] rise, fall, det, pend_set, gnt_clr;
    logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  gnt_sel;
    logic           gnt_found;
    logic           grant;
    logic           evt_valid_q, evt_valid_d;
    logic [IDW-1:0] evt_id_q, evt_id_d;
    logic           evt_rise_q, evt_rise_d;

    // Edge detection against the previous sampled level
    assign rise = s & ~s_r_q;
    assign fall = ~s & s_r_q;
    assign det  = {NCH{en}} & ((cfg_pos & rise) | (cfg_neg & fall));

    // Round-robin pick: first pending channel at or after rr_ptr, wrapping
    always_comb begin : p_pick
        int unsigned j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_sel   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            j = (32'(rr_ptr_q) + k) % NCH;
            if (!gnt_found && pend_q[CW'(j)]) begin
                gnt_found = 1'b1;
                gnt_sel   = CW'(j);
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_rise_d  = evt_rise_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    grant       = 1'b1;
                    state_d     = VALID;
                    evt_valid_d = 1'b1;
                end
            end
            VALID: begin
                if (evt_ready) begin
                    if (gnt_found) begin
                        grant = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        evt_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
        if (grant) begin
            evt_id_d   = IDW'(gnt_sel);
            evt_rise_d = pend_rise_q[gnt_sel];
            rr_ptr_d   = CW'((32'(gnt_sel) + 32'd1) % NCH);
        end
    end

    // Pending slots: a channel granted this cycle may accept a fresh event
    always_comb begin
        gnt_clr     = grant ? ({{(NCH-1){1'b0}}, 1'b1} << gnt_sel) : '0;
        pend_set    = det & (~pend_q | gnt_clr);
        pend_d      = (pend_q & ~gnt_clr) | pend_set;
        pend_rise_d = (pend_rise_q & ~pend_set) | (rise & pend_set);
        ovf_d       = (ovf_q & ~ovf_clr) | (det & pend_q & ~gnt_clr);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            s_r_q       <= '0;
            pend_q      <= '0;
            pend_rise_q <= '0;
            ovf_q       <= '0;
            rr_ptr_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_rise_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_r_q       <= s;
            pend_q      <= pend_d;
            pend_rise_q <= pend_rise_d;
            ovf_q       <= ovf_d;
            rr_ptr_q    <= rr_ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_rise_q  <= evt_rise_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_rise  = evt_rise_q;
    assign ovf       = ovf_q;

`ifdef EDGE_EVT_TS_EN
    logic [TSW-1:0] ts_q;
    logic [TSW-1:0] evt_ts_q, evt_ts_d;
    logic [TSW-1:0] pend_ts_q [NCH];

    assign evt_ts_d = grant ? pend_ts_q[gnt_sel] : evt_ts_q;

    // Free-running timestamp, captured per channel when its slot fills
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_q     <= '0;
            evt_ts_q <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                pend_ts_q[i] <= '0;
            end
        end else begin
            ts_q     <= ts_q + TSW'(1);
            evt_ts_q <= evt_ts_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (pend_set[i]) begin
                    pend_ts_q[i] <= ts_q;
                end
            end
        end
    end

    assign evt_ts = evt_ts_q;
`else
    logic [TSW-1:0] unused_tsw;
    assign unused_tsw = '0;
`endif

endmodule

// File: tb/tb_edge_evt_arb.sv
// Randomised and directed bench for edge_evt_arb against a behavioural event-queue model.
module tb_edge_evt_arb;

    localparam int unsigned NCH = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned TSW = 16;

    logic           clk = 1'b0;
    logic           resetn;
    logic [NCH-1:0] s, cfg_pos, cfg_neg, ovf_clr, ovf;
    logic           en, evt_valid, evt_ready, evt_rise;
    logic [IDW-1:0] evt_id;
`ifdef EDGE_EVT_TS_EN
    logic [TSW-1:0] evt_ts;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: per-channel slots plus the event currently offered
    bit          m_prev [NCH];
    bit          m_pend [NCH];
    bit          m_prise[NCH];
    bit          m_ovf  [NCH];
    int unsigned m_pts  [NCH];
    int          m_ptr;
    bit          m_valid;
    int          m_id;
    bit          m_rise;
    int unsigned m_ts;
    int unsigned m_cnt;

    edge_evt_arb #(.NCH(NCH), .IDW(IDW), .TSW(TSW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s        (s),
        .cfg_pos  (cfg_pos),
        .cfg_neg  (cfg_neg),
        .en       (en),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_rise (evt_rise),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`ifdef EDGE_EVT_TS_EN
        ,
        .evt_ts   (evt_ts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_prev[i] = 0; m_pend[i] = 0; m_prise[i] = 0; m_ovf[i] = 0; m_pts[i] = 0;
        end
        m_ptr = 0; m_valid = 0; m_id = 0; m_rise = 0; m_ts = 0; m_cnt = 0;
    endtask

    // One clock of the event queue, using the inputs about to be sampled
    task automatic m_step();
        bit old_pend[NCH];
        int g;
        g        = -1;
        old_pend = m_pend;
        if (!m_valid || evt_ready) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (g < 0 && old_pend[c]) g = c;
            end
            if (g >= 0) begin
                m_valid = 1; m_id = g; m_rise = m_prise[g]; m_ts = m_pts[g];
                m_pend[g] = 0; m_ptr = (g + 1) % NCH;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            bit r, f, d, lost;
            r    = s[i] && !m_prev[i];
            f    = !s[i] && m_prev[i];
            d    = en && ((cfg_pos[i] && r) || (cfg_neg[i] && f));
            lost = 0;
            if (d) begin
                if (!old_pend[i] || g == i) begin
                    m_pend[i] = 1; m_prise[i] = r; m_pts[i] = m_cnt;
                end else begin
                    lost = 1;
                end
            end
            m_ovf[i]  = (m_ovf[i] && !ovf_clr[i]) || lost;
            m_prev[i] = s[i];
        end
        m_cnt = (m_cnt + 1) % (1 << TSW);
    endtask

    task automatic check_all();
        logic [NCH-1:0] eo;
        for (int i = 0; i < NCH; i++) eo[i] = m_ovf[i];
        chk("valid", 32'(evt_valid), 32'(m_valid));
        chk("ovf", 32'(ovf), 32'(eo));
        if (m_valid) begin
            chk("id", 32'(evt_id), 32'(m_id));
            chk("rise", 32'(evt_rise), 32'(m_rise));
`ifdef EDGE_EVT_TS_EN
            chk("ts", 32'(evt_ts), m_ts);
`endif
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
    task automatic do_reset();
        #2 resetn = 1'b0;
        #1 m_reset();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_rise", 32'(evt_rise), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; s = '0; cfg_pos = '0; cfg_neg = '0; en = 1'b0;
        evt_ready = 1'b0; ovf_clr = '0;
        m_reset();
        #3;
        chk("init_valid", 32'(evt_valid), 32'd0);
        chk("init_ovf", 32'(ovf), 32'd0);
        chk("init_id", 32'(evt_id), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single rising edge on channel 0: two-cycle latency, one-cycle pulse
        en = 1'b1; cfg_pos = 4'b0001; evt_ready = 1'b1;
        tick();
        s = 4'b0001;
        tick(); chk("t1_lat1", 32'(evt_valid), 32'd0);
        tick(); chk("t1_valid", 32'(evt_valid), 32'd1);
        chk("t1_id", 32'(evt_id), 32'd0); chk("t1_rise", 32'(evt_rise), 32'd1);
        tick(); chk("t1_done", 32'(evt_valid), 32'd0);

        // All channels together: back-to-back round robin, then falling edges
        s = '0;
        do_reset();
        cfg_pos = 4'hF; cfg_neg = 4'hF; evt_ready = 1'b1;
        tick();
        s = 4'hF;
        tick();
        for (int k = 0; k < NCH; k++) begin
            tick();
            chk("t2_rv", 32'(evt_valid), 32'd1);
            chk("t2_rid", 32'(evt_id), 32'(k));
            chk("t2_rr", 32'(evt_rise), 32'd1);
        end
        s = '0;
        tick(); chk("t2_gap", 32'(evt_valid), 32'd0);
        for (int k = 0; k < NCH; k++) begin
            tick();
            chk("t2_fid", 32'(evt_id), 32'(k));
            chk("t2_fr", 32'(evt_rise), 32'd0);
        end
        tick(); chk("t2_end", 32'(evt_valid), 32'd0);

        // Overflow: channel 2 rises then falls while its slot is still full
        evt_ready = 1'b0;
        s = 4'b0010; tick(); tick();
        s = 4'b0110; tick();
        s = 4'b0010; tick();
        chk("t3_ovf", 32'(ovf), 32'h4);
        evt_ready = 1'b1;
        tick();
        chk("t3_id", 32'(evt_id), 32'd2); chk("t3_rise", 32'(evt_rise), 32'd1);
        tick(); chk("t3_one", 32'(evt_valid), 32'd0);
        ovf_clr = 4'b0100; tick(); ovf_clr = '0;
        chk("t3_clr", 32'(ovf), 32'd0);

        // en low blocks new detects but not already queued ones
        s = '0;
        do_reset();
        cfg_pos = 4'hF; cfg_neg = 4'hF; evt_ready = 1'b0; en = 1'b1;
        s = 4'b0001; tick(); tick();
        s = 4'b1001; tick();
        en = 1'b0; s = 4'b1011; tick(); tick();
        en = 1'b1; tick();
        evt_ready = 1'b1;
        tick(); chk("t4_id3", 32'(evt_id), 32'd3); chk("t4_v", 32'(evt_valid), 32'd1);
        tick(); chk("t4_none", 32'(evt_valid), 32'd0);

        // Reset mid-handshake, released with channel 0 already high
        evt_ready = 1'b0;
        s = 4'b0000; tick(); tick();
        s = 4'b0001; tick();
        s = 4'b0000; tick();
        chk("t5_pre", 32'(evt_valid), 32'd1);
        s = 4'b0001; cfg_pos = 4'b0001; cfg_neg = '0; evt_ready = 1'b1;
        do_reset();
        tick();
        tick(); chk("t5_v", 32'(evt_valid), 32'd1);
        chk("t5_id", 32'(evt_id), 32'd0); chk("t5_r", 32'(evt_rise), 32'd1);
        tick(); chk("t5_one", 32'(evt_valid), 32'd0);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            s         = NCH'($urandom);
            cfg_pos   = NCH'($urandom);
            cfg_neg   = NCH'($urandom);
            en        = ($urandom_range(0, 9) != 0);
            evt_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
        end
        ovf_clr = '0;

`ifdef EDGE_EVT_TS_EN
        // Timestamp capture at 0x0010 and across the counter wrap
        s = '0;
        do_reset();
        cfg_pos = 4'b0001; cfg_neg = '0; en = 1'b1; evt_ready = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        s = 4'b0001; tick();
        tick(); chk("ts_16", 32'(evt_ts), 32'h10);
        cfg_pos = 4'b0111;
        for (int k = 0; k < 70000 && m_cnt != 32'hFFFF; k++) tick();
        s = 4'b0011; tick();
        s = 4'b0111; tick();
        chk("ts_ffff", 32'(evt_ts), 32'hFFFF); chk("ts_id1", 32'(evt_id), 32'd1);
        tick();
        chk("ts_wrap", 32'(evt_ts), 32'h0); chk("ts_id2", 32'(evt_id), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
